// File: rtl/offset_postinc.sv
// offset_postinc: per-thread post-increment engine for translated addressing offsets.
// A thread counter rotates through THREAD_COUNT threads. ALU writes to the offset
// range load the shadow copy and are forwarded to the offsets RAM one cycle later.
// ALU writes to the increment range load the per-thread increment. A translated
// access by the current thread with a non-zero increment writes shadow+increment
// back to the offsets RAM one cycle later. If the ALU write and the increment
// collide, the ALU write takes the port and the increment is parked in a
// one-entry pending slot.
// Optional feature macro OFFSET_POSTINC_LIMIT_EN: adds per-thread limit registers.
// A non-zero limit folds the sum back by subtracting the limit.
// Ports:
//   clock, reset_n      - clock, asynchronous active-low reset
//   access_valid        - current thread issued a translated access
//   write_addr/data     - ALU write port
//   offsets_wren/_write_addr/_write_data - offsets RAM write port (registered)
//   postinc_overflow    - sticky: an increment was dropped
module offset_postinc #(
  parameter int unsigned OFFSETS_WORD_WIDTH  = 10,
  parameter int unsigned WORD_WIDTH          = 36,
  parameter int unsigned WRITE_ADDR_WIDTH    = 10,
  parameter int unsigned OFFSETS_H_ADDR_BASE = 0,
  parameter int unsigned INC_H_ADDR_BASE     = 8,
  parameter int unsigned LIMIT_H_ADDR_BASE   = 16,
  parameter int unsigned INITIAL_THREAD      = 0,
  parameter int unsigned THREAD_COUNT        = 8,
  parameter int unsigned THREAD_ADDR_WIDTH   = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        access_valid,
  input  logic [WRITE_ADDR_WIDTH-1:0] write_addr,
  input  logic [WORD_WIDTH-1:0]       write_data,
  output logic                        offsets_wren,
  output logic [WRITE_ADDR_WIDTH-1:0] offsets_write_addr,
  output logic [WORD_WIDTH-1:0]       offsets_write_data,
  output logic                        postinc_overflow
);

  localparam int unsigned OW = OFFSETS_WORD_WIDTH;
  localparam int unsigned AW = WRITE_ADDR_WIDTH;
  localparam int unsigned DW = WORD_WIDTH;
  localparam int unsigned TW = THREAD_ADDR_WIDTH;
  localparam logic [AW-1:0] OFF_BASE = AW'(OFFSETS_H_ADDR_BASE);
  localparam logic [AW-1:0] INC_BASE = AW'(INC_H_ADDR_BASE);
  localparam logic [AW-1:0] THR_SPAN = AW'(THREAD_COUNT);
  localparam logic [TW-1:0] THR_LAST = TW'(THREAD_COUNT - 1);
  localparam logic [TW-1:0] THR_INIT = TW'(INITIAL_THREAD);

  logic [TW-1:0] thread;
  logic [OW-1:0] shadow    [THREAD_COUNT];
  logic [OW-1:0] increment [THREAD_COUNT];
  logic          pend_valid;
  logic [TW-1:0] pend_thread;
  logic [OW-1:0] pend_data;

  // Only the low offset bits of the ALU word are meaningful here.
  logic [OW-1:0] alu_word;
  logic          unused_data_bits;
  assign alu_word         = write_data[OW-1:0];
  assign unused_data_bits = &{1'b0, write_data[DW-1:OW]};

  // Address decode of the ALU write port.
  logic [AW-1:0] off_rel, inc_rel;
  logic          off_hit, inc_hit;
  logic [TW-1:0] off_t, inc_t;
  assign off_rel = write_addr - OFF_BASE;
  assign inc_rel = write_addr - INC_BASE;
  assign off_hit = (write_addr >= OFF_BASE) && (off_rel < THR_SPAN);
  assign inc_hit = (write_addr >= INC_BASE) && (inc_rel < THR_SPAN);
  assign off_t   = TW'(off_rel);
  assign inc_t   = TW'(inc_rel);

  logic [OW-1:0] cur_shadow, cur_inc, new_off;
  assign cur_shadow = shadow[thread];
  assign cur_inc    = increment[thread];

`ifdef OFFSET_POSTINC_LIMIT_EN
  localparam logic [AW-1:0] LIM_BASE = AW'(LIMIT_H_ADDR_BASE);
  logic [OW-1:0] limit [THREAD_COUNT];
  logic [AW-1:0] lim_rel;
  logic          lim_hit;
  logic [TW-1:0] lim_t;
  logic [OW-1:0] cur_limit;
  logic [OW:0]   sum;
  assign lim_rel   = write_addr - LIM_BASE;
  assign lim_hit   = (write_addr >= LIM_BASE) && (lim_rel < THR_SPAN);
  assign lim_t     = TW'(lim_rel);
  assign cur_limit = limit[thread];

  // Sum is compared against the limit before any modulo wrap.
  always_comb begin
    sum     = {1'b0, cur_shadow} + {1'b0, cur_inc};
    new_off = sum[OW-1:0];
    if ((cur_limit != '0) && (sum >= {1'b0, cur_limit})) begin
      new_off = OW'(sum - {1'b0, cur_limit});
    end
  end

  // Limit registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(THREAD_COUNT); i++) limit[i] <= '0;
    end else if (lim_hit) begin
      limit[lim_t] <= alu_word;
    end
  end
`else
  localparam logic [AW-1:0] lim_base_unused = AW'(LIMIT_H_ADDR_BASE);
  assign new_off = cur_shadow + cur_inc;
`endif

  // Request classification for this cycle.
  logic inc_req, inc_live, pend_live;
  assign inc_req   = access_valid && (cur_inc != '0);
  assign inc_live  = inc_req && !(off_hit && (off_t == thread));
  assign pend_live = pend_valid && !(off_hit && (off_t == pend_thread));

  // Port arbitration: ALU forward, then pending entry, then fresh increment.
  logic          nxt_wren;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_data;
  logic          nxt_pend_valid;
  logic [TW-1:0] nxt_pend_thread;
  logic [OW-1:0] nxt_pend_data;
  logic          inc_commit, inc_drop;

  always_comb begin
    nxt_wren        = 1'b0;
    nxt_addr        = '0;
    nxt_data        = '0;
    nxt_pend_valid  = pend_live;
    nxt_pend_thread = pend_thread;
    nxt_pend_data   = pend_data;
    inc_commit      = 1'b0;
    inc_drop        = 1'b0;
    if (off_hit) begin
      nxt_wren = 1'b1;
      nxt_addr = write_addr;
      nxt_data = DW'(alu_word);
      if (inc_live) begin
        if (pend_live) begin
          inc_drop = 1'b1;
        end else begin
          nxt_pend_valid  = 1'b1;
          nxt_pend_thread = thread;
          nxt_pend_data   = new_off;
          inc_commit      = 1'b1;
        end
      end
    end else if (pend_live) begin
      nxt_wren        = 1'b1;
      nxt_addr        = OFF_BASE + AW'(pend_thread);
      nxt_data        = DW'(pend_data);
      nxt_pend_valid  = inc_live;
      nxt_pend_thread = thread;
      nxt_pend_data   = new_off;
      inc_commit      = inc_live;
    end else if (inc_live) begin
      nxt_wren   = 1'b1;
      nxt_addr   = OFF_BASE + AW'(thread);
      nxt_data   = DW'(new_off);
      inc_commit = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      thread             <= THR_INIT;
      pend_valid         <= 1'b0;
      pend_thread        <= '0;
      pend_data          <= '0;
      offsets_wren       <= 1'b0;
      offsets_write_addr <= '0;
      offsets_write_data <= '0;
      postinc_overflow   <= 1'b0;
      for (int i = 0; i < int'(THREAD_COUNT); i++) begin
        shadow[i]    <= '0;
        increment[i] <= '0;
      end
    end else begin
      thread             <= (thread == THR_LAST) ? '0 : thread + TW'(1);
      pend_valid         <= nxt_pend_valid;
      pend_thread        <= nxt_pend_thread;
      pend_data          <= nxt_pend_data;
      offsets_wren       <= nxt_wren;
      offsets_write_addr <= nxt_addr;
      offsets_write_data <= nxt_data;
      if (inc_drop)   postinc_overflow  <= 1'b1;
      if (off_hit)    shadow[off_t]     <= alu_word;
      if (inc_commit) shadow[thread]    <= new_off;
      if (inc_hit)    increment[inc_t]  <= alu_word;
    end
  end

endmodule

// File: tb/tb_offset_postinc.sv
// Directed bench for offset_postinc: table of single-access vectors plus
// hand-written collision, overflow, cancel and reset sequences.
module tb_offset_postinc;

  localparam logic [9:0] IDLE_ADDR = 10'd1000;
  localparam int OFF_B = 0;
  localparam int INC_B = 8;
  localparam int LIM_B = 16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        access_valid = 1'b0;
  logic [9:0]  write_addr = IDLE_ADDR;
  logic [35:0] write_data = '0;
  logic        offsets_wren;
  logic [9:0]  offsets_write_addr;
  logic [35:0] offsets_write_data;
  logic        postinc_overflow;

  int errors = 0;
  int checks = 0;
  int tb_thr;

  offset_postinc dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .access_valid       (access_valid),
    .write_addr         (write_addr),
    .write_data         (write_data),
    .offsets_wren       (offsets_wren),
    .offsets_write_addr (offsets_write_addr),
    .offsets_write_data (offsets_write_data),
    .postinc_overflow   (postinc_overflow)
  );

  always #5 clock = ~clock;

  // Reference thread counter.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_thr <= 0;
    else          tb_thr <= (tb_thr + 1) % 8;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_out(input string name, input bit wren, input int addr, input int data);
    check({name, ".wren"}, 64'(offsets_wren), 64'(wren));
    check({name, ".addr"}, 64'(offsets_write_addr), 64'(addr));
    check({name, ".data"}, 64'(offsets_write_data), 64'(data));
  endtask

  task automatic alu_write(input int addr, input logic [35:0] data);
    write_addr = 10'(addr);
    write_data = data;
    step();
    write_addr = IDLE_ADDR;
    write_data = '0;
  endtask

  task automatic wait_thr(input int t);
    for (int i = 0; i < 16 && tb_thr != t; i++) step();
    check("wait_thread", 64'(tb_thr), 64'(t));
  endtask

  // Access by thread t, optionally with a simultaneous ALU write.
  task automatic access(input int t, input bit with_alu, input int addr, input int data);
    wait_thr(t);
    access_valid = 1'b1;
    if (with_alu) begin
      write_addr = 10'(addr);
      write_data = 36'(data);
    end
    step();
    access_valid = 1'b0;
    write_addr   = IDLE_ADDR;
    write_data   = '0;
  endtask

  typedef struct {
    int thr;
    int sh;
    int inc;
    int lim;
    bit exp_wren;
    int exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
`ifdef OFFSET_POSTINC_LIMIT_EN
    vecs[3] = '{5, 14, 4, 16, 1'b1, 2};
    vecs[7] = '{5, -1, -1, -1, 1'b1, 6};
`else
    vecs[3] = '{5, 14, 4, 16, 1'b1, 18};
    vecs[7] = '{5, -1, -1, -1, 1'b1, 22};
`endif
    vecs[0] = '{2, 5, 3, -1, 1'b1, 8};
    vecs[1] = '{0, 1020, 7, -1, 1'b1, 3};
    vecs[2] = '{7, 0, 1, -1, 1'b1, 1};
    vecs[4] = '{3, 1023, 1023, -1, 1'b1, 1022};
    vecs[5] = '{6, 100, 0, -1, 1'b0, 0};
    vecs[6] = '{2, -1, -1, -1, 1'b1, 11};

    // Reset state
    #12;
    check_out("reset", 1'b0, 0, 0);
    check("reset.ovf", 64'(postinc_overflow), 64'd0);
    #10;
    reset_n = 1'b1;
    step();
    check_out("post_reset", 1'b0, 0, 0);

    // Table of single accesses
    foreach (vecs[k]) begin
      if (vecs[k].sh >= 0) begin
        alu_write(OFF_B + vecs[k].thr, 36'(vecs[k].sh) | 36'hC00000000);
        check_out($sformatf("vec%0d.fwd", k), 1'b1, OFF_B + vecs[k].thr, vecs[k].sh);
      end
      if (vecs[k].inc >= 0) begin
        alu_write(INC_B + vecs[k].thr, 36'(vecs[k].inc));
        check($sformatf("vec%0d.inc_nofwd", k), 64'(offsets_wren), 64'd0);
      end
      if (vecs[k].lim >= 0) begin
        alu_write(LIM_B + vecs[k].thr, 36'(vecs[k].lim));
        check($sformatf("vec%0d.lim_nofwd", k), 64'(offsets_wren), 64'd0);
      end
      access(vecs[k].thr, 1'b0, 0, 0);
      check_out($sformatf("vec%0d.acc", k), vecs[k].exp_wren,
                vecs[k].exp_wren ? OFF_B + vecs[k].thr : 0, vecs[k].exp_data);
      step();
      check($sformatf("vec%0d.idle", k), 64'(offsets_wren), 64'd0);
    end

    // Same-thread collision: ALU value wins, increment discarded silently
    alu_write(OFF_B + 1, 36'd50);
    alu_write(INC_B + 1, 36'd2);
    access(1, 1'b1, OFF_B + 1, 100);
    check_out("same_thr", 1'b1, 1, 100);
    step();
    check("same_thr.after", 64'(offsets_wren), 64'd0);
    check("same_thr.ovf", 64'(postinc_overflow), 64'd0);
    access(1, 1'b0, 0, 0);
    check_out("same_thr.next", 1'b1, 1, 102);

    // Different-thread collision: increment deferred one cycle
    alu_write(OFF_B + 3, 36'd10);
    alu_write(INC_B + 3, 36'd5);
    access(3, 1'b1, OFF_B + 4, 77);
    check_out("defer.alu", 1'b1, 4, 77);
    step();
    check_out("defer.pend", 1'b1, 3, 15);
    step();
    check("defer.idle", 64'(offsets_wren), 64'd0);
    check("defer.ovf", 64'(postinc_overflow), 64'd0);

    // Pending full and port busy: new increment dropped, overflow set
    alu_write(INC_B + 4, 36'd1);
    access(3, 1'b1, OFF_B + 4, 1);
    check_out("ovf.alu1", 1'b1, 4, 1);
    access(4, 1'b1, OFF_B + 6, 9);
    check_out("ovf.alu2", 1'b1, 6, 9);
    check("ovf.set", 64'(postinc_overflow), 64'd1);
    step();
    check_out("ovf.pend", 1'b1, 3, 20);
    step();
    check("ovf.idle", 64'(offsets_wren), 64'd0);
    check("ovf.sticky", 64'(postinc_overflow), 64'd1);
    access(4, 1'b0, 0, 0);
    check_out("ovf.shadow_kept", 1'b1, 4, 2);

    // ALU write to the pending thread cancels the pending entry
    access(3, 1'b1, OFF_B + 4, 50);
    check_out("cancel.alu1", 1'b1, 4, 50);
    alu_write(OFF_B + 3, 36'd200);
    check_out("cancel.alu2", 1'b1, 3, 200);
    step();
    check("cancel.idle", 64'(offsets_wren), 64'd0);
    access(3, 1'b0, 0, 0);
    check_out("cancel.next", 1'b1, 3, 205);

    // Reset while an entry is pending
    access(3, 1'b1, OFF_B + 4, 60);
    check_out("rst.alu", 1'b1, 4, 60);
    reset_n = 1'b0;
    #1;
    check_out("rst.async", 1'b0, 0, 0);
    check("rst.ovf", 64'(postinc_overflow), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check_out("rst.release1", 1'b0, 0, 0);
    step();
    check_out("rst.release2", 1'b0, 0, 0);
    alu_write(INC_B + 5, 36'd1);
    access(5, 1'b0, 0, 0);
    check_out("rst.cleared", 1'b1, 5, 1);
    alu_write(OFF_B + 2, 36'd9);
    alu_write(INC_B + 2, 36'd1);
    access(2, 1'b0, 0, 0);
    check_out("rst.thread", 1'b1, 2, 10);
    check("rst.ovf_end", 64'(postinc_overflow), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
